// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states and default bus widths.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  localparam int APB_AW = 4;
  localparam int APB_DW = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request after ptr, searching cyclically.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// Round-robin shared APB master: arbitrates NREQ requesters and runs
// SETUP/ACCESS with wait states and an optional access timeout.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16,
  parameter int IW      = $clog2(NREQ)
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_done,
  output logic               req_err,
  output logic [DW-1:0]      rsp_rdata,
  output logic [IW-1:0]      gnt_id,
  output logic               busy,
  output logic [AW-1:0]      paddr,
  output logic               pwrite,
  output logic               psel,
  output logic               penable,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  logic [CW-1:0]   wcnt;
  logic [NREQ-1:0] gnt_vec;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  // gnt_id doubles as the round-robin pointer
  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (gnt_id),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      gnt_vec   <= '0;
      gnt_id    <= IW'(NREQ - 1);
      req_done  <= '0;
      req_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwdata    <= '0;
    end else begin
      req_done <= '0;
      req_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_id  <= arb_idx;
            gnt_vec <= arb_gnt;
            pwrite  <= req_write[arb_idx];
            paddr   <= req_addr[int'(arb_idx)*AW +: AW];
            pwdata  <= req_wdata[int'(arb_idx)*DW +: DW];
            psel    <= 1'b1;
            busy    <= 1'b1;
            wcnt    <= '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            req_done <= gnt_vec;
            if (!pwrite) rsp_rdata <= prdata;
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (TIMEOUT != 0 && wcnt == WLAST) begin
            req_done <= gnt_vec;
            req_err  <= 1'b1;
            psel     <= 1'b0;
            penable  <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: vector table, hand sequences, random vs model.
module tb_apb_arb_master;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int TMO  = 4;
  localparam int IW   = 2;

  logic               pclk = 1'b0;
  logic               rst  = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_write = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_done;
  logic               req_err;
  logic [DW-1:0]      rsp_rdata;
  logic [IW-1:0]      gnt_id;
  logic               busy;
  logic [AW-1:0]      paddr;
  logic               pwrite;
  logic               psel;
  logic               penable;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata = '0;
  logic               pready = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  apb_arb_master #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TMO),
    .IW      (IW)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .rsp_rdata (rsp_rdata),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  typedef struct {
    int              gid;
    int              lat;
    int              acc;
    logic            err;
    logic [DW-1:0]   rd;
    logic [NREQ-1:0] done;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic            w;
    logic            proto_ok;
  } obs_t;

  typedef struct {
    int          id;
    logic        wr;
    logic [3:0]  a;
    logic [7:0]  d;
    int          waits;
    logic [7:0]  rd;
    int          acc;
    logic        err;
    logic [7:0]  erd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_cmd(input int id, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[id]            = w;
    req_addr[id*AW +: AW]    = a;
    req_wdata[id*DW +: DW]   = d;
  endtask

  // Called at a negedge; returns at the negedge where req_done is seen.
  task automatic run(input int waits, input logic [DW-1:0] rd,
                     input bit jitter, output obs_t o);
    o.gid = -1; o.lat = 0; o.acc = 0; o.err = 1'bx;
    o.rd = 'x; o.done = '0; o.a = 'x; o.d = 'x; o.w = 1'bx;
    o.proto_ok = 1'b0;
    pready = 1'b0;
    prdata = rd;
    while (!psel && o.lat < 8) begin
      @(negedge pclk);
      o.lat++;
    end
    if (!psel) begin
      chk("setup_timeout", 32'(psel), 32'd1);
      return;
    end
    o.proto_ok = !penable && busy;
    o.gid = int'(gnt_id);
    o.a = paddr; o.d = pwdata; o.w = pwrite;
    @(negedge pclk);
    for (int n = 1; n <= 20; n++) begin
      if (!(psel && penable && busy)) o.proto_ok = 1'b0;
      if (paddr !== o.a || pwdata !== o.d) o.proto_ok = 1'b0;
      pready = (n > waits);
      if (jitter) req_valid = NREQ'($urandom);
      @(negedge pclk);
      if (req_done != '0) begin
        o.acc  = n;
        o.done = req_done;
        o.err  = req_err;
        o.rd   = rsp_rdata;
        if (psel || penable) o.proto_ok = 1'b0;
        break;
      end
    end
    pready = 1'b0;
  endtask

  vec_t tbl[6];
  obs_t o;
  int   ptr;
  logic [DW-1:0] mrd;

  initial begin
    #400000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1'b1, 4'h2, 8'h05, 0, 8'h00, 1, 1'b0, 8'h00};
    tbl[1] = '{0, 1'b0, 4'h3, 8'h11, 2, 8'h0A, 3, 1'b0, 8'h0A};
    tbl[2] = '{2, 1'b0, 4'h7, 8'h22, 9, 8'h55, 4, 1'b1, 8'h0A};
    tbl[3] = '{1, 1'b0, 4'h1, 8'h33, 3, 8'h3C, 4, 1'b0, 8'h3C};
    tbl[4] = '{2, 1'b1, 4'hF, 8'hFF, 1, 8'hAA, 2, 1'b0, 8'h3C};
    tbl[5] = '{0, 1'b1, 4'h0, 8'h00, 9, 8'h77, 4, 1'b1, 8'h3C};

    // Reset with requests pending: nothing may be selected
    req_valid = 3'b111;
    req_write = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("rst_psel", 32'(psel), 32'd0);
    end
    chk("rst_outs", {req_done, req_err, busy, pwrite, psel, penable},
        32'd0);
    chk("rst_bus", {paddr, pwdata, rsp_rdata}, 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd2);
    rst = 1'b0;

    // Contention: all requesters always valid
    for (int k = 0; k < 6; k++) begin
      run(0, 8'h00, 1'b0, o);
      chk("cont_gnt", 32'(o.gid), 32'(k % NREQ));
      chk("cont_idle", 32'(o.lat), 32'd1);
      chk("cont_done", 32'(o.done), 32'(1 << (k % NREQ)));
    end
    req_valid = '0;

    // Table of single-requester transfers
    for (int i = 0; i < 6; i++) begin
      set_cmd(tbl[i].id, tbl[i].wr, tbl[i].a, tbl[i].d);
      req_valid = NREQ'(1 << tbl[i].id);
      run(tbl[i].waits, tbl[i].rd, 1'b0, o);
      req_valid = '0;
      chk($sformatf("tbl%0d_gnt", i), 32'(o.gid), 32'(tbl[i].id));
      chk($sformatf("tbl%0d_proto", i), 32'(o.proto_ok), 32'd1);
      chk($sformatf("tbl%0d_cmd", i), {o.w, o.a, o.d},
          {tbl[i].wr, tbl[i].a, tbl[i].d});
      chk($sformatf("tbl%0d_acc", i), 32'(o.acc), 32'(tbl[i].acc));
      chk($sformatf("tbl%0d_done", i), 32'(o.done),
          32'(1 << tbl[i].id));
      chk($sformatf("tbl%0d_err", i), 32'(o.err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_rdata", i), 32'(o.rd), 32'(tbl[i].erd));
    end

    // Timeout then the next requester still gets its turn
    req_valid = 3'b111;
    run(9, 8'h99, 1'b0, o);
    chk("to_gnt", 32'(o.gid), 32'd1);
    chk("to_err", 32'(o.err), 32'd1);
    chk("to_rdata", 32'(o.rd), 32'h3C);
    run(0, 8'h00, 1'b0, o);
    chk("to_next_gnt", 32'(o.gid), 32'd2);
    chk("to_next_err", 32'(o.err), 32'd0);
    req_valid = '0;
    @(negedge pclk);

    // Reset between clock edges during a wait state
    req_valid = 3'b001;
    pready = 1'b0;
    @(negedge pclk);
    chk("mr_setup", 32'(psel), 32'd1);
    @(negedge pclk);
    @(negedge pclk);
    chk("mr_access", {psel, penable}, 32'b11);
    #2 rst = 1'b1;
    #1;
    chk("mr_async", {psel, penable, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("mr_nodone", 32'(req_done), 32'd0);
    end
    rst = 1'b0;
    req_valid = 3'b111;
    run(0, 8'h00, 1'b0, o);
    chk("mr_restart", 32'(o.gid), 32'd0);
    chk("mr_rdata", 32'(o.rd), 32'd0);

    // Random transfers against a round-robin/timeout model
    ptr = 0;
    mrd = 8'h00;
    for (int it = 0; it < 60; it++) begin
      int waits, eg, eacc;
      logic [NREQ-1:0] vec;
      logic [DW-1:0] rd;
      logic eerr;
      vec = NREQ'($urandom_range(1, 7));
      req_write = NREQ'($urandom);
      req_addr  = (NREQ*AW)'($urandom);
      req_wdata = (NREQ*DW)'($urandom);
      waits = $urandom_range(0, 6);
      rd = DW'($urandom);
      eg = -1;
      for (int k = 1; k <= NREQ; k++)
        if (eg < 0 && vec[(ptr + k) % NREQ]) eg = (ptr + k) % NREQ;
      eerr = (waits >= TMO);
      eacc = eerr ? TMO : waits + 1;
      if (!eerr && !req_write[eg]) mrd = rd;
      req_valid = vec;
      run(waits, rd, 1'b1, o);
      req_valid = '0;
      chk("rnd_gnt", 32'(o.gid), 32'(eg));
      chk("rnd_cmd", {o.w, o.a, o.d},
          {req_write[eg], req_addr[eg*AW +: AW], req_wdata[eg*DW +: DW]});
      chk("rnd_acc", 32'(o.acc), 32'(eacc));
      chk("rnd_err", 32'(o.err), 32'(eerr));
      chk("rnd_done", 32'(o.done), 32'(1 << eg));
      chk("rnd_rdata", 32'(o.rd), 32'(mrd));
      chk("rnd_proto", 32'(o.proto_ok), 32'd1);
      ptr = eg;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
